// File: rtl/env_trap_seq.sv
// env_trap_seq: ECALL/EBREAK trap sequencer for the 5-stage core.
// This block accepts a trap from the decode stage. It freezes fetch and flushes
// the front end while older instructions drain through E/M/W. It then holds the
// core halted until the host asks to resume. Fetch is then redirected to EPC+4.
//
// Optional feature: define ENV_TRAP_CNT_EN to add a saturating 32-bit TrapCount
// output. It counts DRAIN entries.
//
// Ports
//   clk, reset       core clock, synchronous active-high reset
//   EcallD, EbreakD  trap flags decoded in D
//   StallD, FlushD   D stage stalled/flushed; a trap is not accepted while set
//   PCD              PC of the instruction in D
//   ResumeReq        host resume request (level), only honoured while halted
//   TrapStallF       stall PC/fetch register
//   TrapFlushD       flush F/D register
//   TrapFlushE       flush D/E register
//   Halted           core halted awaiting host
//   TrapCause        00 none, 01 ecall, 10 ebreak
//   EPC              PC of the trapping instruction
//   RedirectF        one-cycle fetch redirect strobe
//   RedirectPC       EPC+4 while RedirectF is high, else 0
//   TrapCount        (ENV_TRAP_CNT_EN only) number of traps taken, saturating
//
// state  | meaning
// IDLE   | normal execution, watching D for ECALL/EBREAK
// DRAIN  | front end frozen, older instructions retiring
// HALT   | core parked, waiting for ResumeReq
// RESUME | single-cycle redirect of fetch to EPC+4
module env_trap_seq #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            EcallD,
    input  logic            EbreakD,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [XLEN-1:0] PCD,
    input  logic            ResumeReq,
    output logic            TrapStallF,
    output logic            TrapFlushD,
    output logic            TrapFlushE,
    output logic            Halted,
    output logic [1:0]      TrapCause,
    output logic [XLEN-1:0] EPC,
    output logic            RedirectF,
    output logic [XLEN-1:0] RedirectPC
`ifdef ENV_TRAP_CNT_EN
    ,
    output logic [31:0]     TrapCount
`endif
);

    // A drain length of 0 still needs one cycle in DRAIN.
    localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
    localparam int CW        = (DRAIN_EFF > 1) ? $clog2(DRAIN_EFF) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_HALT   = 2'd2,
        S_RESUME = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [1:0]      cause_q, cause_d;
    logic            take;

    assign take = (EcallD | EbreakD) & ~StallD & ~FlushD;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            epc_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        epc_d      = epc_q;
        cause_d    = cause_q;
        TrapStallF = 1'b0;
        TrapFlushD = 1'b0;
        TrapFlushE = 1'b0;
        Halted     = 1'b0;
        RedirectF  = 1'b0;
        RedirectPC = '0;
        unique case (state_q)
            S_IDLE: begin
                if (take) begin
                    epc_d   = PCD;
                    cause_d = EbreakD ? 2'b10 : 2'b01;
                    count_d = CW'(DRAIN_EFF - 1);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                TrapStallF = 1'b1;
                TrapFlushD = 1'b1;
                TrapFlushE = 1'b1;
                if (count_q == '0) state_d = S_HALT;
                else               count_d = count_q - 1'b1;
            end
            S_HALT: begin
                TrapStallF = 1'b1;
                TrapFlushD = 1'b1;
                TrapFlushE = 1'b1;
                Halted     = 1'b1;
                if (ResumeReq) state_d = S_RESUME;
            end
            S_RESUME: begin
                TrapFlushD = 1'b1;
                RedirectF  = 1'b1;
                RedirectPC = epc_q + XLEN'(4);
                // Clearing the trap context here makes IDLE outputs all-zero.
                epc_d      = '0;
                cause_d    = 2'b00;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign TrapCause = cause_q;
    assign EPC       = epc_q;

`ifdef ENV_TRAP_CNT_EN
    logic [31:0] trap_cnt_q, trap_cnt_d;

    always_comb begin
        trap_cnt_d = trap_cnt_q;
        if (state_q == S_IDLE && take && trap_cnt_q != 32'hFFFF_FFFF)
            trap_cnt_d = trap_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) trap_cnt_q <= '0;
        else       trap_cnt_q <= trap_cnt_d;
    end

    assign TrapCount = trap_cnt_q;
`endif

endmodule

// File: tb/tb_env_trap_seq.sv
module tb_env_trap_seq;

    localparam int D = 3;

    logic        clk = 1'b0;
    logic        reset, EcallD, EbreakD, StallD, FlushD, ResumeReq;
    logic [31:0] PCD;
    logic        TrapStallF, TrapFlushD, TrapFlushE, Halted, RedirectF;
    logic [1:0]  TrapCause;
    logic [31:0] EPC, RedirectPC;
`ifdef ENV_TRAP_CNT_EN
    logic [31:0] TrapCount;
`endif

    env_trap_seq #(.XLEN(32), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .EcallD(EcallD), .EbreakD(EbreakD),
        .StallD(StallD), .FlushD(FlushD), .PCD(PCD), .ResumeReq(ResumeReq),
        .TrapStallF(TrapStallF), .TrapFlushD(TrapFlushD), .TrapFlushE(TrapFlushE),
        .Halted(Halted), .TrapCause(TrapCause), .EPC(EPC),
        .RedirectF(RedirectF), .RedirectPC(RedirectPC)
`ifdef ENV_TRAP_CNT_EN
        , .TrapCount(TrapCount)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: trap lifetime tracked as "busy", cycles since acceptance,
    // and whether the redirect cycle is in progress.
    bit          m_busy, m_redir;
    int          m_age;
    logic [31:0] m_epc, m_cnt;
    logic [1:0]  m_cause;

    function automatic logic [70:0] pk(input logic sf, fd, fe, h, input logic [1:0] c,
                                       input logic rf, input logic [31:0] epc, rpc);
        return {sf, fd, fe, h, c, rf, epc, rpc};
    endfunction

    function automatic logic [70:0] model_exp();
        if (!m_busy) return '0;
        return pk(!m_redir, 1'b1, !m_redir, !m_redir && (m_age > D), m_cause,
                  m_redir, m_epc, m_redir ? m_epc + 32'd4 : 32'd0);
    endfunction

    task automatic model_step(input logic r, ec, eb, st, fl, input logic [31:0] pc, input logic rs);
        if (r) begin
            m_busy = 0; m_redir = 0; m_age = 0; m_epc = '0; m_cause = '0; m_cnt = '0;
        end else if (!m_busy) begin
            if ((ec | eb) && !st && !fl) begin
                m_busy  = 1; m_age = 1; m_epc = pc;
                m_cause = eb ? 2'b10 : 2'b01;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
        end else if (m_redir) begin
            m_busy = 0; m_redir = 0; m_epc = '0; m_cause = '0;
        end else if (m_age > D && rs) begin
            m_redir = 1;
        end else if (m_age < 1000) begin
            m_age++;
        end
    endtask

    // Drive one cycle of inputs (at negedge) and return at the next negedge.
    task automatic cyc(input logic r, ec, eb, st, fl, input logic [31:0] pc, input logic rs);
        reset = r; EcallD = ec; EbreakD = eb; StallD = st; FlushD = fl; PCD = pc; ResumeReq = rs;
        model_step(r, ec, eb, st, fl, pc, rs);
        @(negedge clk);
    endtask

    task automatic check_outs(input string name, input logic [70:0] exp);
        logic [70:0] act;
        act = pk(TrapStallF, TrapFlushD, TrapFlushE, Halted, TrapCause, RedirectF, EPC, RedirectPC);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got sF/fD/fE/H/cause/rF=%b epc=%h rpc=%h, expected %b epc=%h rpc=%h",
                     name, act[70:64], act[63:32], act[31:0], exp[70:64], exp[63:32], exp[31:0]);
        end
`ifdef ENV_TRAP_CNT_EN
        n_tests++;
        if (TrapCount !== m_cnt) begin
            n_fail++;
            $display("FAIL %s_count: got %h expected %h", name, TrapCount, m_cnt);
        end
`endif
    endtask

    typedef struct {
        logic        r, ec, eb, st, fl;
        logic [31:0] pc;
        logic        rs;
        logic [70:0] exp;
    } vec_t;

    function automatic vec_t mkv(input logic r, ec, eb, st, fl, input logic [31:0] pc,
                                 input logic rs, input logic [70:0] exp);
        vec_t v;
        v.r = r; v.ec = ec; v.eb = eb; v.st = st; v.fl = fl; v.pc = pc; v.rs = rs; v.exp = exp;
        return v;
    endfunction

    initial begin
        vec_t        vt[19];
        logic [70:0] z, dr40, ha40, dr80, ha80;
        int          pulses;
        logic [31:0] rpc_seen;

        z    = '0;
        dr40 = pk(1, 1, 1, 0, 2'b01, 0, 32'h40, 32'h0);
        ha40 = pk(1, 1, 1, 1, 2'b01, 0, 32'h40, 32'h0);
        dr80 = pk(1, 1, 1, 0, 2'b10, 0, 32'h80, 32'h0);
        ha80 = pk(1, 1, 1, 1, 2'b10, 0, 32'h80, 32'h0);
        //                r  ec eb st fl  pc      rs  expected after the edge
        vt[0]  = mkv(1, 0, 0, 0, 0, 32'h0,   0, z);
        vt[1]  = mkv(1, 0, 0, 0, 0, 32'h0,   0, z);
        vt[2]  = mkv(0, 0, 0, 0, 0, 32'h0,   0, z);
        vt[3]  = mkv(0, 1, 0, 0, 0, 32'h40,  0, dr40);
        vt[4]  = mkv(0, 0, 0, 0, 0, 32'h44,  0, dr40);
        vt[5]  = mkv(0, 0, 0, 0, 0, 32'h48,  0, dr40);
        vt[6]  = mkv(0, 0, 0, 0, 0, 32'h4c,  0, ha40);
        vt[7]  = mkv(0, 1, 0, 0, 0, 32'h50,  0, ha40);
        vt[8]  = mkv(0, 0, 0, 0, 0, 32'h0,   1, pk(0, 1, 0, 0, 2'b01, 1, 32'h40, 32'h44));
        vt[9]  = mkv(0, 0, 0, 0, 0, 32'h0,   0, z);
        vt[10] = mkv(0, 0, 0, 0, 0, 32'h0,   0, z);
        vt[11] = mkv(0, 1, 1, 1, 0, 32'h80,  0, z);
        vt[12] = mkv(0, 1, 1, 0, 1, 32'h80,  0, z);
        vt[13] = mkv(0, 1, 1, 0, 0, 32'h80,  0, dr80);
        vt[14] = mkv(0, 1, 1, 0, 0, 32'h200, 0, dr80);
        vt[15] = mkv(0, 0, 0, 0, 0, 32'h0,   1, dr80);
        vt[16] = mkv(0, 0, 0, 0, 0, 32'h0,   0, ha80);
        vt[17] = mkv(0, 0, 0, 0, 0, 32'h0,   1, pk(0, 1, 0, 0, 2'b10, 1, 32'h80, 32'h84));
        vt[18] = mkv(0, 0, 0, 0, 0, 32'h0,   1, z);

        reset = 1; EcallD = 0; EbreakD = 0; StallD = 0; FlushD = 0; PCD = '0; ResumeReq = 0;
        m_busy = 0; m_redir = 0; m_age = 0; m_epc = '0; m_cause = '0; m_cnt = '0;
        @(negedge clk);

        foreach (vt[i]) begin
            cyc(vt[i].r, vt[i].ec, vt[i].eb, vt[i].st, vt[i].fl, vt[i].pc, vt[i].rs);
            check_outs($sformatf("vec%0d", i), vt[i].exp);
        end

        // Ebreak at top of address space; resume held for 5 cycles.
        cyc(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0);
        for (int i = 0; i < D; i++) cyc(0, 0, 0, 0, 0, 32'h0, 0);
        check_outs("t4_halt", pk(1, 1, 1, 1, 2'b10, 0, 32'hFFFF_FFFC, 32'h0));
        pulses = 0; rpc_seen = 32'hDEAD_BEEF;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 32'h0, 1);
            if (RedirectF) begin pulses++; rpc_seen = RedirectPC; end
        end
        cyc(0, 0, 0, 0, 0, 32'h0, 0);
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL t4_pulses: got %0d expected 1", pulses);
        end
        n_tests++;
        if (rpc_seen !== 32'h0) begin
            n_fail++; $display("FAIL t4_wrap: got %h expected 00000000", rpc_seen);
        end
        check_outs("t4_idle", z);

        // Reset mid-DRAIN, then mid-HALT, then a normal trap.
        cyc(0, 1, 0, 0, 0, 32'h300, 0);
        check_outs("t5_drain", pk(1, 1, 1, 0, 2'b01, 0, 32'h300, 32'h0));
        cyc(1, 0, 0, 0, 0, 32'h0, 0);
        check_outs("t5_rst_drain", z);
        cyc(0, 1, 0, 0, 0, 32'h304, 0);
        for (int i = 0; i < D + 1; i++) cyc(0, 0, 0, 0, 0, 32'h0, 0);
        check_outs("t5_halt", pk(1, 1, 1, 1, 2'b01, 0, 32'h304, 32'h0));
        cyc(1, 0, 0, 0, 0, 32'h0, 1);
        check_outs("t5_rst_halt", z);
        cyc(0, 1, 0, 0, 0, 32'h100, 0);
        for (int i = 0; i < D; i++) cyc(0, 0, 0, 0, 0, 32'h0, 0);
        check_outs("t5_retrap", pk(1, 1, 1, 1, 2'b01, 0, 32'h100, 32'h0));
        cyc(0, 0, 0, 0, 0, 32'h0, 1);
        check_outs("t5_redirect", pk(0, 1, 0, 0, 2'b01, 1, 32'h100, 32'h104));
        cyc(0, 0, 0, 0, 0, 32'h0, 0);

`ifdef ENV_TRAP_CNT_EN
        cyc(1, 0, 0, 0, 0, 32'h0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 0, 32'h1000 + 32'(k * 4), 0);
            for (int i = 0; i < D; i++) cyc(0, 0, 0, 0, 0, 32'h0, 0);
            cyc(0, 0, 0, 0, 0, 32'h0, 1);
            cyc(0, 0, 0, 0, 0, 32'h0, 0);
        end
        check_outs("t6_three", z);
        force dut.trap_cnt_q = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 release dut.trap_cnt_q;
        @(negedge clk);
        m_cnt = 32'hFFFF_FFFF;
        cyc(0, 0, 1, 0, 0, 32'h2000, 0);
        check_outs("t6_sat", pk(1, 1, 1, 0, 2'b10, 0, 32'h2000, 32'h0));
`endif

        // Randomised traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(99) < 3, $urandom_range(99) < 30, $urandom_range(99) < 20,
                $urandom_range(99) < 25, $urandom_range(99) < 15,
                ($urandom_range(99) < 10) ? 32'hFFFF_FFFC : $urandom,
                $urandom_range(99) < 30);
            check_outs($sformatf("rand%0d", i), model_exp());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
